// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared IF/ID types and constants for the LEGv8 pipeline.
//   XLEN          - default PC width
//   ILEN          - default instruction width
//   if_id_entry_t - {pc, instr} pair carried across the IF/ID boundary
//   NOP_INSTR     - all-zero bubble that decode sees while valid_D is low
package pipeline_pkg;
    localparam int XLEN = 64;
    localparam int ILEN = 32;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } if_id_entry_t;
    localparam logic [ILEN-1:0] NOP_INSTR = '0;
endpackage

// File: rtl/queue_ptr.sv
// queue_ptr: wrapping W-bit pointer with async active-low reset, clear and increment.
//   clk   - clock
//   rst_n - asynchronous active-low reset (pointer -> 0)
//   clr_i - synchronous clear to 0, dominates inc_i
//   inc_i - advance by one, wrapping modulo 2**W
//   ptr_o - current pointer value
module queue_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);
    logic [W-1:0] ptr_q, ptr_d;
    always_comb ptr_d = clr_i ? '0 : inc_i ? ptr_q + W'(1) : ptr_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    assign ptr_o = ptr_q;
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: in-order {PC, instruction} buffer between fetch and decode.
//   clk          - clock, all state on rising edge
//   reset        - asynchronous active-low reset
//   push_valid_F - fetch offers {pc_F, instr_F}
//   pc_F/instr_F - fetched PC and instruction word
//   full_F       - queue full, fetch must stall
//   flush        - taken branch, discard everything (beats push and pop)
//   valid_D      - head entry valid
//   ready_D      - decode accepts head entry
//   pc_D/instr_D - head entry, zero / NOP_INSTR while empty
//   count        - occupied entries
module if_id_queue
    import pipeline_pkg::*;
#(
    parameter int N     = XLEN,
    parameter int IW    = ILEN,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_valid_F,
    input  logic [N-1:0]               pc_F,
    input  logic [IW-1:0]              instr_F,
    output logic                       full_F,
    input  logic                       flush,
    output logic                       valid_D,
    input  logic                       ready_D,
    output logic [N-1:0]               pc_D,
    output logic [IW-1:0]              instr_D,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [N-1:0]  pc_mem    [DEPTH];
    logic [IW-1:0] instr_mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    // Push is refused while full even if a pop happens the same cycle (no bypass).
    assign full_F  = count_q == CW'(DEPTH);
    assign valid_D = count_q != '0;
    assign push    = push_valid_F && !full_F && !flush;
    assign pop     = valid_D && ready_D && !flush;

    queue_ptr #(.W(AW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (flush),
        .inc_i (push),
        .ptr_o (wr_ptr)
    );

    queue_ptr #(.W(AW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (flush),
        .inc_i (pop),
        .ptr_o (rd_ptr)
    );

    always_comb
        count_d = flush           ? '0 :
                  push && !pop    ? count_q + CW'(1) :
                  pop && !push    ? count_q - CW'(1) :
                  count_q;

    always_ff @(posedge clk or negedge reset)
        if (!reset) count_q <= '0;
        else        count_q <= count_d;

    // Storage is intentionally left unreset; valid_D gates what decode sees.
    always_ff @(posedge clk)
        if (push) begin
            pc_mem[wr_ptr]    <= pc_F;
            instr_mem[wr_ptr] <= instr_F;
        end

    assign pc_D    = valid_D ? pc_mem[rd_ptr]    : '0;
    assign instr_D = valid_D ? instr_mem[rd_ptr] : IW'(NOP_INSTR);
    assign count   = count_q;
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed plus randomized checks of if_id_queue against a queue-based model.
module tb_if_id_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        push_valid_F = 1'b0;
    logic [63:0] pc_F = '0;
    logic [31:0] instr_F = '0;
    logic        full_F;
    logic        flush = 1'b0;
    logic        valid_D;
    logic        ready_D = 1'b0;
    logic [63:0] pc_D;
    logic [31:0] instr_D;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    logic [63:0] pcq [$];
    logic [31:0] inq [$];

    if_id_queue #(.N(64), .IW(32), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .push_valid_F (push_valid_F),
        .pc_F         (pc_F),
        .instr_F      (instr_F),
        .full_F       (full_F),
        .flush        (flush),
        .valid_D      (valid_D),
        .ready_D      (ready_D),
        .pc_D         (pc_D),
        .instr_D      (instr_D),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n = pcq.size();
        check({tag, ".count"}, 64'(count), 64'(n));
        check({tag, ".valid"}, 64'(valid_D), 64'(n != 0));
        check({tag, ".full"}, 64'(full_F), 64'(n == DEPTH));
        check({tag, ".pc"}, pc_D, n != 0 ? pcq[0] : 64'h0);
        check({tag, ".instr"}, 64'(instr_D), n != 0 ? 64'(inq[0]) : 64'h0);
    endtask

    // One clock: drive, clock, apply the FIFO rules to the model, then compare.
    task automatic step(input string tag, input logic pv, input logic [63:0] pc,
                        input logic [31:0] ins, input logic rdy, input logic fl);
        bit do_pop, do_push;
        push_valid_F = pv;
        pc_F = pc;
        instr_F = ins;
        ready_D = rdy;
        flush = fl;
        @(posedge clk);
        if (fl) begin
            pcq.delete();
            inq.delete();
        end else begin
            do_pop  = rdy && pcq.size() != 0;
            do_push = pv && pcq.size() < DEPTH;
            if (do_pop) begin
                void'(pcq.pop_front());
                void'(inq.pop_front());
            end
            if (do_push) begin
                pcq.push_back(pc);
                inq.push_back(ins);
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        #1 reset = 1'b0;
        #10;
        check_all("reset");
        reset = 1'b1;
        #3;

        for (int i = 0; i < 4; i++) step("fill", 1, 64'(i * 4), $urandom, 0, 0);
        check("fill.full4", 64'(full_F), 64'h1);
        step("refuse", 1, 64'h10, $urandom, 0, 0);
        check("refuse.count", 64'(count), 64'h4);

        for (int i = 0; i < 4; i++) begin
            check("drain.head", pc_D, 64'(i * 4));
            step("drain", 0, 0, 0, 1, 0);
        end
        check("drain.pc0", pc_D, 64'h0);

        step("pp", 1, 64'h100, $urandom, 0, 0);
        step("pp", 1, 64'h104, $urandom, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step("pp", 1, 64'h108 + 64'(i * 4), $urandom, 1, 0);
            check("pp.count2", 64'(count), 64'h2);
        end

        step("fl", 1, 64'h200, $urandom, 0, 0);
        step("fl", 1, 64'h204, $urandom, 0, 0);
        step("fl", 1, 64'h208, $urandom, 0, 0);
        step("flush", 1, 64'h20c, $urandom, 1, 1);
        check("flush.count", 64'(count), 64'h0);

        for (int i = 0; i < 4; i++) step("full", 1, 64'h300 + 64'(i * 4), $urandom, 0, 0);
        step("fullpp", 1, 64'h310, $urandom, 1, 0);
        check("fullpp.count", 64'(count), 64'h3);
        check("fullpp.head", pc_D, 64'h304);
        step("drop", 1, 64'h314, $urandom, 1, 1);

        step("ar", 1, 64'h400, $urandom, 0, 0);
        step("ar", 1, 64'h404, $urandom, 0, 0);
        #2 reset = 1'b0;
        #1;
        pcq.delete();
        inq.delete();
        check("areset.valid", 64'(valid_D), 64'h0);
        check("areset.count", 64'(count), 64'h0);
        #3 reset = 1'b1;
        step("post", 1, 64'h40, 32'hdeadbeef, 0, 0);
        check("post.pc", pc_D, 64'h40);

        for (int i = 0; i < 3000; i++)
            step("rand", 1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, $urandom,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction buffer between the fetch stage and decode (IF/ID boundary) of the pipelined LEGv8 core.
- Captures {PC, instruction} pairs produced by fetch/imem each cycle and presents them in order to decode via a valid/ready handshake.
- Raises a stall toward fetch when full, and discards all contents on a taken branch (flush).

Parameters:
N, 64, address/PC width
IW, 32, instruction width
DEPTH, 4, number of entries; power of two, >= 2

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
push_valid_F  input  1  fetch presents a valid {pc_F, instr_F} this cycle
pc_F  input  N  PC of fetched instruction (imem_addr_F)
instr_F  input  IW  instruction word read from imem at pc_F
full_F  output  1  queue full; fetch must hold PC (stall)
flush  input  1  taken branch resolved (PCSrc_F); discard all entries
valid_D  output  1  head entry valid for decode
ready_D  input  1  decode accepts head entry this cycle
pc_D  output  N  PC of head entry
instr_D  output  IW  instruction of head entry
count  output  $clog2(DEPTH+1)  number of occupied entries

Behaviour:
- Reset (reset==0, async): count=0, rd_ptr=wr_ptr=0, valid_D=0, pc_D=0, instr_D=0, full_F=0. Storage array contents are not reset.
- Storage: DEPTH-entry circular array; wr_ptr/rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH with no extra logic.
- Push accepted iff push_valid_F && !full_F && !flush. The entry is written at wr_ptr and wr_ptr increments.
- Pop occurs iff valid_D && ready_D && !flush. rd_ptr increments.
- count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- full_F = (count==DEPTH), combinational from registered count. A push while full is refused even if a pop happens the same cycle; there is no bypass.
- valid_D = (count!=0). pc_D and instr_D show the array entry at rd_ptr when valid_D=1, and are forced to 0 when valid_D=0.
- Latency: an entry pushed at edge k is visible on valid_D/pc_D/instr_D after edge k. There is no same-cycle fall-through.
- Flush has priority over push and pop. At the next edge count=0, rd_ptr=wr_ptr=0, valid_D=0.
  - A push_valid_F in the flush cycle is dropped.
  - A ready_D in the flush cycle does not count as a pop.
- Empty with ready_D=1: no effect, and count does not underflow.
- Reset asserted mid-operation: immediate clear as above. After release, the first push lands in entry 0.
- Order is strictly FIFO; pc_D for consecutive pops equals the push order of pc_F.

Decomposition:
- Shared package (pipeline_pkg) holds:
  - typedef if_id_entry_t = struct {logic [N-1:0] pc; logic [IW-1:0] instr;}
  - constant NOP_INSTR (all-zero bubble encoding) used by decode when valid_D=0.
- One sub-module, queue_ptr: a log2(DEPTH)-bit wrapping pointer with async active-low reset, clear, and increment enable. It is instantiated twice (rd, wr).
- Count logic and storage are inline.

Test Plan:
- Reset then 4 pushes (pc_F=0x0,0x4,0x8,0xC), ready_D=0 -> count=4, full_F=1 after the 4th edge; a 5th push (pc 0x10) is refused and count stays 4.
- From full, ready_D=1 for 4 cycles with no push -> pc_D sequence 0x0,0x4,0x8,0xC, then valid_D=0, pc_D=0, count=0.
- Continuous push+pop with count=2 -> count stays 2 every cycle. After 10 pushes the pointers have wrapped and pc_D order still matches push order.
- count=3, then flush=1 with push_valid_F=1 and ready_D=1 in the same cycle -> next cycle count=0, valid_D=0, and the pushed entry is absent.
- Full queue, push_valid_F=1 and ready_D=1 together -> the pop occurs, the push is refused, count=3, full_F=0 next cycle.
- reset driven 0 asynchronously between edges with count=2 -> valid_D=0, count=0 immediately. After release, a push of pc 0x40 appears on pc_D one edge later.
